// File: rtl/spm_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Widest operand the helpers handle; WIDTH is limited to 2..32.
  localparam int MAX_W = 32;

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Two's-complement magnitude of a zero-extended operand. The caller keeps
  // the low WIDTH bits, which are exact modulo 2^WIDTH, so the most negative
  // value maps to 2^(WIDTH-1) with no overflow.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v,
                                                input logic             neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/spm_mag_sign.sv
// Operand conditioning: converts both operands to unsigned magnitudes and
// derives the sign the final product must carry.
module spm_mag_sign
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_is_signed,
  output logic [WIDTH-1:0] o_x_mag,
  output logic [WIDTH-1:0] o_y_mag,
  output logic             o_sign
);

  logic w_x_neg;
  logic w_y_neg;

  // An operand is negated only when signed mode is selected and its MSB is set.
  assign w_x_neg = i_is_signed & i_x[WIDTH-1];
  assign w_y_neg = i_is_signed & i_y[WIDTH-1];

  assign o_x_mag = WIDTH'(twos_mag(MAX_W'(i_x), w_x_neg));
  assign o_y_mag = WIDTH'(twos_mag(MAX_W'(i_y), w_y_neg));
  assign o_sign  = i_is_signed & (i_x[WIDTH-1] ^ i_y[WIDTH-1]);

endmodule

// File: rtl/spm_seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or
// unsigned per operation, start/busy/done handshake.
module spm_seq_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int PROD_W = prod_w(WIDTH);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_acc;
  logic [WIDTH-1:0]    r_x_mag;
  logic [WIDTH-1:0]    r_y_mag;
  logic                r_sign;
  logic                r_busy;
  logic                r_done;
  logic [PROD_W-1:0]   r_prod;

  logic [WIDTH-1:0]    w_x_mag;
  logic [WIDTH-1:0]    w_y_mag;
  logic                w_sign;
  logic                w_accept;
  logic [PROD_W-1:0]   w_addend;

  spm_mag_sign #(
    .WIDTH (WIDTH)
  ) u_mag_sign (
    .i_x         (x),
    .i_y         (y),
    .i_is_signed (is_signed),
    .o_x_mag     (w_x_mag),
    .o_y_mag     (w_y_mag),
    .o_sign      (w_sign)
  );

  // A request is taken in IDLE and also on the result edge (FIX), so a held
  // start yields one operation every WIDTH+1 cycles with no idle gap.
  assign w_accept = start && ((r_state == IDLE) || (r_state == FIX));

  // Multiplicand magnitude aligned to the bit position being retired.
  assign w_addend = PROD_W'(r_x_mag) << r_cnt;

  // Control FSM and shift-add datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_x_mag <= '0;
      r_y_mag <= '0;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_prod  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
        end
        RUN: begin
          if (r_y_mag[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_y_mag <= r_y_mag >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_prod  <= r_sign ? (~r_acc + PROD_W'(1)) : r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // Capture overrides the FIX-edge release when a new request is waiting.
      if (w_accept) begin
        r_x_mag <= w_x_mag;
        r_y_mag <= w_y_mag;
        r_sign  <= w_sign;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
        r_state <= RUN;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign prod = r_prod;

endmodule

// File: tb/tb_spm_seq_mult.sv
// Testbench for spm_seq_mult: WIDTH=8 directed/random scenarios and an
// exhaustive WIDTH=4 sweep, checked against an arithmetic reference model.
module tb_spm_seq_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st8 = 1'b0, s8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        st4 = 1'b0, s4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spm_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .is_signed(s8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .prod(prod8)
  );

  spm_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .is_signed(s4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .prod(prod4)
  );

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic longint ref_prod(input longint a, input longint b,
                                      input int w, input bit s);
    longint va, vb, p;
    va = a;
    vb = b;
    if (s && a[w-1]) va = a - (longint'(1) << w);
    if (s && b[w-1]) vb = b - (longint'(1) << w);
    p = va * vb;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Issue one WIDTH=8 operation; report product, edges to done, busy cycles.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] p, output int lat, output int bcnt);
    x8 = a; y8 = b; s8 = s; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    lat = -1; bcnt = 0; p = '0;
    for (int n = 1; n <= 40; n++) begin
      if (busy8) bcnt++;
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        p = prod8;
        break;
      end
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      output logic [7:0] p, output int lat);
    x4 = a; y4 = b; s4 = s; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    lat = -1; p = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = n;
        p = prod4;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL rst_busy8 got %b exp 0", busy8); end
    n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL rst_done8 got %b exp 0", done8); end
    n_vec++; if (prod8 !== 16'h0000) begin n_err++; $display("FAIL rst_prod8 got %h exp 0000", prod8); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rst_busy4 got %b exp 0", busy4); end
    n_vec++; if (prod4 !== 8'h00) begin n_err++; $display("FAIL rst_prod4 got %h exp 00", prod4); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_min_min;
    logic [15:0] p; int lat, bc;
    run8(8'h80, 8'h80, 1'b1, p, lat, bc);
    n_vec++; if (p !== 16'h4000) begin n_err++; $display("FAIL minmin_prod got %h exp 4000", p); end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL minmin_latency got %0d exp 9", lat); end
    n_vec++; if (bc != 9) begin n_err++; $display("FAIL minmin_busy_cycles got %0d exp 9", bc); end
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL minmin_busy_at_done got %b exp 0", busy8); end
    @(posedge clk); #1;
    n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL minmin_done_pulse got %b exp 0", done8); end
    n_vec++; if (prod8 !== 16'h4000) begin n_err++; $display("FAIL minmin_prod_hold got %h exp 4000", prod8); end
  endtask

  task automatic test_max;
    logic [15:0] p; int lat, bc;
    run8(8'hFF, 8'hFF, 1'b0, p, lat, bc);
    n_vec++; if (p !== 16'hFE01) begin n_err++; $display("FAIL umax_prod got %h exp fe01", p); end
    run8(8'hFF, 8'hFF, 1'b1, p, lat, bc);
    n_vec++; if (p !== 16'h0001) begin n_err++; $display("FAIL sneg1_prod got %h exp 0001", p); end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL sneg1_latency got %0d exp 9", lat); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p1, p2; int t1, t2;
    x8 = 8'hFD; y8 = 8'h05; s8 = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    x8 = 8'h00; y8 = 8'hF9;
    t1 = -1; t2 = -1; p1 = '0; p2 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin t1 = n; p1 = prod8; break; end
    end
    st8 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin t2 = n; p2 = prod8; break; end
    end
    n_vec++; if (p1 !== 16'hFFF1) begin n_err++; $display("FAIL b2b_first_prod got %h exp fff1", p1); end
    n_vec++; if (t1 != 9) begin n_err++; $display("FAIL b2b_first_latency got %0d exp 9", t1); end
    n_vec++; if (p2 !== 16'h0000) begin n_err++; $display("FAIL b2b_second_prod got %h exp 0000", p2); end
    n_vec++; if (t2 != 9) begin n_err++; $display("FAIL b2b_gap got %0d exp 9", t2); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy;
    logic [15:0] p; int e, lat, dcnt;
    x8 = 8'd7; y8 = 8'd6; s8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    x8 = 8'd1; y8 = 8'd1; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    e = 3; dcnt = 0; lat = -1; p = '0;
    while (e < 40) begin
      @(posedge clk); #1;
      e++;
      if (done8) begin
        dcnt++;
        if (dcnt == 1) begin lat = e; p = prod8; end
      end
    end
    n_vec++; if (dcnt != 1) begin n_err++; $display("FAIL ignore_done_count got %0d exp 1", dcnt); end
    n_vec++; if (p !== 16'd42) begin n_err++; $display("FAIL ignore_prod got %0d exp 42", p); end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL ignore_latency got %0d exp 9", lat); end
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] p; int lat, bc, dcnt;
    x8 = 8'd100; y8 = 8'd100; s8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy8); end
    n_vec++; if (prod8 !== 16'h0000) begin n_err++; $display("FAIL midrst_prod got %h exp 0000", prod8); end
    n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b exp 0", done8); end
    rst = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    n_vec++; if (dcnt != 0) begin n_err++; $display("FAIL midrst_spurious_done got %0d exp 0", dcnt); end
    run8(8'd2, 8'd3, 1'b0, p, lat, bc);
    n_vec++; if (p !== 16'd6) begin n_err++; $display("FAIL postrst_prod got %0d exp 6", p); end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL postrst_latency got %0d exp 9", lat); end
  endtask

  task automatic test_random8;
    logic [15:0] p, exp_p; logic [7:0] a, b; logic s; int lat, bc;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      exp_p = 16'(ref_prod(longint'(a), longint'(b), 8, s));
      run8(a, b, s, p, lat, bc);
      n_vec++;
      if (p !== exp_p || lat != 9) begin
        n_err++;
        $display("FAIL rand8 a=%h b=%h s=%b got %h lat %0d exp %h lat 9", a, b, s, p, lat, exp_p);
      end
    end
  endtask

  task automatic test_sweep4;
    logic [7:0] p, exp_p; int lat;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp_p = 8'(ref_prod(longint'(a), longint'(b), 4, s[0]));
          run4(4'(a), 4'(b), s[0], p, lat);
          n_vec++;
          if (p !== exp_p || lat != 5) begin
            n_err++;
            $display("FAIL sweep4 a=%0d b=%0d s=%0d got %h lat %0d exp %h lat 5", a, b, s, p, lat, exp_p);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_min_min;
    test_max;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid_op;
    test_random8;
    test_sweep4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
